wr_rptr_rx: RTL and testbench

WR_RPTR_RX -- requirements
Module: wr_rptr_rx

---
 rtl/async_fifo_pkg.sv | 23 ++
 rtl/ptr_sync.sv | 30 +++
 rtl/wr_rptr_rx.sv | 95 +++++++++
 tb/tb_wr_rptr_rx.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/async_fifo_pkg.sv
// rtl/async_fifo_pkg.sv - shared write-side FSM encoding and gray/binary helper
package async_fifo_pkg;

   // Widest pointer the helper supports; callers zero-extend and truncate.
   localparam int PTR_MAXW = 32;

   typedef enum logic [1:0] {
      S_NORMAL = 2'd0,
      S_AFULL  = 2'd1,
      S_FULL   = 2'd2
   } wstate_e;

   // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
   function automatic logic [PTR_MAXW-1:0] gray2bin(input logic [PTR_MAXW-1:0] g);
      logic [PTR_MAXW-1:0] b;
      b[PTR_MAXW-1] = g[PTR_MAXW-1];
      for (int i = PTR_MAXW - 2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/ptr_sync.sv
// rtl/ptr_sync.sv - multi-flop synchronizer for a gray pointer into w_clk
module ptr_sync #(
   parameter int WIDTH  = 5,
   parameter int STAGES = 2
) (
   input  logic             w_clk,
   input  logic             w_rst,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] stg [STAGES];

   // Shift the asynchronous pointer through the flop chain; only the last stage is trusted.
   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         for (int i = 0; i < STAGES; i++) begin
            stg[i] <= '0;
         end
      end else begin
         stg[0] <= d;
         for (int i = 1; i < STAGES; i++) begin
            stg[i] <= stg[i-1];
         end
      end
   end

   assign q = stg[STAGES-1];

endmodule

// File: rtl/wr_rptr_rx.sv
// rtl/wr_rptr_rx.sv - write-side read-pointer receiver: level, almost-full, full, overflow
module wr_rptr_rx
   import async_fifo_pkg::*;
#(
   parameter int ADDR_WIDTH  = 4,
   parameter int SYNC_STAGES = 2,
   parameter int AF_LEVEL    = 12,
   parameter int AF_HYST     = 2
) (
   input  logic                w_clk,
   input  logic                w_rst,
   input  logic [ADDR_WIDTH:0] r_ptr,
   input  logic [ADDR_WIDTH:0] w_ptr,
   input  logic                w_valid,
   output logic                w_ready,
   output logic                winc,
   output logic [ADDR_WIDTH:0] wlevel,
   output logic                walmost_full,
   output logic                wfull,
   output logic                woverflow_err
);

   localparam int PW = ADDR_WIDTH + 1;
   localparam logic [PW-1:0] DEPTH_L = PW'(2 ** ADDR_WIDTH);
   localparam logic [PW-1:0] AF_HI   = PW'(AF_LEVEL);
   localparam logic [PW-1:0] AF_LO   = PW'(AF_LEVEL - AF_HYST);

   logic [PW-1:0] r_sync;
   logic [PW-1:0] rbin;
   logic [PW-1:0] wbin;
   logic [PW-1:0] lvl_next;
   wstate_e       state;
   wstate_e       state_nxt;

   ptr_sync #(
      .WIDTH  (PW),
      .STAGES (SYNC_STAGES)
   ) u_rptr_sync (
      .w_clk (w_clk),
      .w_rst (w_rst),
      .d     (r_ptr),
      .q     (r_sync)
   );

   assign rbin = PW'(gray2bin(PTR_MAXW'(r_sync)));
   assign wbin = PW'(gray2bin(PTR_MAXW'(w_ptr)));

   // Handshake is gated by reset so no write escapes while the block is held in reset.
   assign w_ready  = ~wfull;
   assign winc     = w_valid & w_ready & w_rst;

   // Occupancy after this cycle's write; modular arithmetic absorbs pointer wrap.
   assign lvl_next = (wbin + PW'(winc)) - rbin;

   assign wfull        = (state == S_FULL);
   assign walmost_full = (state != S_NORMAL);

   // Next-state: full has priority, inconsistent pointers freeze the state.
   always_comb begin
      state_nxt = state;
      if (lvl_next > DEPTH_L) begin
         state_nxt = state;
      end else if (lvl_next == DEPTH_L) begin
         state_nxt = S_FULL;
      end else begin
         case (state)
            S_NORMAL: if (lvl_next >= AF_HI) state_nxt = S_AFULL;
            S_AFULL:  if (lvl_next < AF_LO)  state_nxt = S_NORMAL;
            S_FULL:   state_nxt = (lvl_next < AF_LO) ? S_NORMAL : S_AFULL;
            default:  state_nxt = S_NORMAL;
         endcase
      end
   end

   // State register.
   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         state <= S_NORMAL;
      end else begin
         state <= state_nxt;
      end
   end

   // Registered level and sticky pointer-inconsistency flag.
   always_ff @(posedge w_clk or negedge w_rst) begin
      if (!w_rst) begin
         wlevel        <= '0;
         woverflow_err <= 1'b0;
      end else begin
         wlevel        <= lvl_next;
         woverflow_err <= woverflow_err | (lvl_next > DEPTH_L);
      end
   end

endmodule

// File: tb/tb_wr_rptr_rx.sv
// tb/tb_wr_rptr_rx.sv - directed scoreboard bench for wr_rptr_rx
module tb_wr_rptr_rx;

   localparam int S = 2;

   logic       w_clk = 1'b0;
   logic       w_rst;
   logic [4:0] r_ptr;
   logic [4:0] w_ptr;
   logic       w_valid;
   logic       w_ready;
   logic       winc;
   logic [4:0] wlevel;
   logic       walmost_full;
   logic       wfull;
   logic       woverflow_err;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic [4:0] lvl;
      logic       af;
      logic       full;
      logic       err;
   } exp_t;

   exp_t sb[$];

   logic [4:0] tb_wbin;
   logic [4:0] tb_rbin;
   logic [4:0] rhist [S];
   logic       m_af;
   logic       m_full;
   logic       m_err;

   wr_rptr_rx #(
      .ADDR_WIDTH  (4),
      .SYNC_STAGES (S),
      .AF_LEVEL    (12),
      .AF_HYST     (2)
   ) dut (
      .w_clk         (w_clk),
      .w_rst         (w_rst),
      .r_ptr         (r_ptr),
      .w_ptr         (w_ptr),
      .w_valid       (w_valid),
      .w_ready       (w_ready),
      .winc          (winc),
      .wlevel        (wlevel),
      .walmost_full  (walmost_full),
      .wfull         (wfull),
      .woverflow_err (woverflow_err)
   );

   always #5 w_clk = ~w_clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   function automatic logic [4:0] gray(input logic [4:0] b);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic model_clear();
      tb_wbin = '0;
      tb_rbin = '0;
      for (int i = 0; i < S; i++) rhist[i] = '0;
      m_af   = 1'b0;
      m_full = 1'b0;
      m_err  = 1'b0;
      sb.delete();
      w_ptr = '0;
      r_ptr = '0;
   endtask

   // One clock of stimulus: predict, push, clock, pop and compare.
   task automatic step(input logic v);
      exp_t       e;
      logic       ew;
      logic [4:0] l;
      w_valid = v;
      w_ptr   = gray(tb_wbin);
      r_ptr   = gray(tb_rbin);
      #1;
      ew = v & ~m_full;
      chk("winc", {7'd0, winc}, {7'd0, ew});
      chk("w_ready", {7'd0, w_ready}, {7'd0, ~m_full});
      l = tb_wbin + {4'd0, ew} - rhist[S-1];
      if (l > 5'd16) begin
         m_err = 1'b1;
      end else if (l == 5'd16) begin
         m_full = 1'b1;
         m_af   = 1'b1;
      end else begin
         m_full = 1'b0;
         if (l >= 5'd12) m_af = 1'b1;
         else if (l < 5'd10) m_af = 1'b0;
      end
      e.lvl  = l;
      e.af   = m_af;
      e.full = m_full;
      e.err  = m_err;
      sb.push_back(e);
      @(posedge w_clk);
      for (int i = S - 1; i > 0; i--) rhist[i] = rhist[i-1];
      rhist[0] = tb_rbin;
      tb_wbin  = tb_wbin + {4'd0, ew};
      #1;
      e = sb.pop_front();
      chk("wlevel", {3'd0, wlevel}, {3'd0, e.lvl});
      chk("walmost_full", {7'd0, walmost_full}, {7'd0, e.af});
      chk("wfull", {7'd0, wfull}, {7'd0, e.full});
      chk("woverflow_err", {7'd0, woverflow_err}, {7'd0, e.err});
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_wlevel"}, {3'd0, wlevel}, 8'd0);
      chk({tag, "_af"}, {7'd0, walmost_full}, 8'd0);
      chk({tag, "_full"}, {7'd0, wfull}, 8'd0);
      chk({tag, "_err"}, {7'd0, woverflow_err}, 8'd0);
      chk({tag, "_w_ready"}, {7'd0, w_ready}, 8'd1);
      chk({tag, "_winc"}, {7'd0, winc}, 8'd0);
   endtask

   initial begin
      w_rst   = 1'b0;
      w_valid = 1'b1;
      model_clear();
      #2;
      chk_reset_outputs("por");
      repeat (2) @(posedge w_clk);
      #1 w_rst = 1'b1;

      // Fill from empty with a static read pointer; the 17th request is blocked.
      for (int i = 0; i < 17; i++) step(1'b1);
      chk("fill_wlevel", {3'd0, wlevel}, 8'd16);
      chk("fill_wfull", {7'd0, wfull}, 8'd1);
      chk("fill_wbin", {3'd0, tb_wbin}, 8'd16);

      // One read advance clears full exactly S+1 clocks later.
      tb_rbin = 5'd1;
      step(1'b0);
      chk("rd1_full_c1", {7'd0, wfull}, 8'd1);
      step(1'b0);
      chk("rd1_full_c2", {7'd0, wfull}, 8'd1);
      step(1'b0);
      chk("rd1_full_c3", {7'd0, wfull}, 8'd0);
      chk("rd1_wlevel", {3'd0, wlevel}, 8'd15);
      step(1'b1);
      chk("refill_wlevel", {3'd0, wlevel}, 8'd16);
      chk("refill_full", {7'd0, wfull}, 8'd1);

      // Drain through the almost-full hysteresis band.
      repeat (4) begin tb_rbin = tb_rbin + 5'd1; step(1'b0); end
      repeat (S) step(1'b0);
      chk("drain12_wlevel", {3'd0, wlevel}, 8'd12);
      chk("drain12_af", {7'd0, walmost_full}, 8'd1);
      repeat (2) begin tb_rbin = tb_rbin + 5'd1; step(1'b0); end
      repeat (S) step(1'b0);
      chk("drain10_wlevel", {3'd0, wlevel}, 8'd10);
      chk("drain10_af", {7'd0, walmost_full}, 8'd1);
      tb_rbin = tb_rbin + 5'd1;
      step(1'b0);
      repeat (S) step(1'b0);
      chk("drain9_wlevel", {3'd0, wlevel}, 8'd9);
      chk("drain9_af", {7'd0, walmost_full}, 8'd0);

      // Equal-rate write and read through several pointer wraps.
      for (int i = 0; i < 100; i++) begin
         tb_rbin = tb_rbin + 5'd1;
         step(1'b1);
         chk("stream_band", {7'd0, (wlevel >= 5'd6) && (wlevel <= 5'd12)}, 8'd1);
      end
      repeat (S) step(1'b0);
      chk("stream_wlevel", {3'd0, wlevel}, 8'd9);
      chk("stream_err", {7'd0, woverflow_err}, 8'd0);

      // Inconsistent write pointer raises a sticky error.
      tb_wbin = tb_rbin + 5'd17;
      step(1'b0);
      chk("ovf_err", {7'd0, woverflow_err}, 8'd1);
      chk("ovf_wlevel", {3'd0, wlevel}, 8'd17);
      chk("ovf_full_held", {7'd0, wfull}, 8'd0);
      tb_wbin = tb_rbin + 5'd3;
      repeat (3) step(1'b0);
      chk("ovf_sticky", {7'd0, woverflow_err}, 8'd1);
      w_rst = 1'b0;
      model_clear();
      #1;
      chk("ovf_cleared", {7'd0, woverflow_err}, 8'd0);
      repeat (2) @(posedge w_clk);
      #1 w_rst = 1'b1;

      // Mid-stream reset at level 7.
      for (int i = 0; i < 7; i++) step(1'b1);
      chk("pre_rst_wlevel", {3'd0, wlevel}, 8'd7);
      w_valid = 1'b1;
      w_rst   = 1'b0;
      model_clear();
      #1;
      chk_reset_outputs("midrst");
      repeat (2) @(posedge w_clk);
      #1;
      chk_reset_outputs("midrst_hold");
      w_rst = 1'b1;
      step(1'b0);
      chk("post_rst_wlevel", {3'd0, wlevel}, 8'd0);
      chk("post_rst_ready", {7'd0, w_ready}, 8'd1);
      step(1'b1);
      chk("post_rst_write", {3'd0, wlevel}, 8'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
